// File: rtl/seq_divider_hex.sv
// Sequential 8-bit / 4-bit restoring divider with 7-segment and LED display.
// Ports: CLOCK_50 clock; KEY[0] async active-low reset, KEY[1] start button;
//   SW[7:0] dividend, SW[17:14] divisor; HEX0/HEX1 quotient, HEX2 remainder,
//   HEX3 dark; LEDR {div0, busy, done, 3'b0, remainder, quotient}.
// Option: define DIV_DEBOUNCE_EN to debounce KEY[1] for DEBOUNCE_CYCLES.
module seq_divider_hex #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [17:0] LEDR
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    logic       rst_n;
    logic       sync1;
    logic       sync2;
    logic       level;
    logic       prev;
    logic [1:0] settle;
    logic       armed;
    logic       start;

    state_t     state;
    state_t     state_nxt;

    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [4:0] prem;
    logic [7:0] qwork;
    logic [2:0] step;
    logic [7:0] quot;
    logic [3:0] rem;
    logic       done;
    logic       busy;
    logic       div0;

    logic [4:0] trial;
    logic       ge;
    logic [4:0] prem_nxt;
    logic [7:0] qwork_nxt;

    logic       unused_bits;

    assign rst_n = KEY[0];
    assign unused_bits = ^{KEY[3:2], SW[13:8], prem[4]};

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= KEY[1];
            sync2 <= sync1;
        end
    end

`ifdef DIV_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ?
                        $clog2(DEBOUNCE_CYCLES) : 1;

    logic          db_level;
    logic [CW-1:0] db_cnt;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            db_level <= 1'b1;
            db_cnt   <= '0;
        end else if (sync2 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_level <= sync2;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign level = db_level;
`else
    assign level = sync2;
`endif

    // Edges are honoured only once the synchronizer has flushed its reset
    // value and the button has been seen released, so a key held through
    // reset cannot fake a press.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            settle <= 2'd0;
            armed  <= 1'b0;
            prev   <= 1'b1;
        end else begin
            if (settle != 2'd3) begin
                settle <= settle + 2'd1;
            end
            if (settle == 2'd3 && sync2) begin
                armed <= 1'b1;
            end
            prev <= level;
        end
    end

    assign start = armed & prev & ~level;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = (dvs == 4'd0) ? DONE : RUN;
            end
            RUN: begin
                if (step == 3'd7) begin
                    state_nxt = DONE;
                end
            end
        endcase
    end

    // Remainder stays below the divisor, so its low 4 bits plus the next
    // dividend bit hold the whole trial value.
    always_comb begin
        trial     = {prem[3:0], dvd[7]};
        ge        = (trial >= {1'b0, dvs});
        prem_nxt  = ge ? (trial - {1'b0, dvs}) : trial;
        qwork_nxt = {qwork[6:0], ge};
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            dvd   <= 8'd0;
            dvs   <= 4'd0;
            prem  <= 5'd0;
            qwork <= 8'd0;
            step  <= 3'd0;
            quot  <= 8'd0;
            rem   <= 4'd0;
            done  <= 1'b0;
            busy  <= 1'b0;
            div0  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dvd   <= SW[7:0];
                        dvs   <= SW[17:14];
                        prem  <= 5'd0;
                        qwork <= 8'd0;
                        step  <= 3'd0;
                        done  <= 1'b0;
                        div0  <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (dvs == 4'd0) begin
                        quot <= 8'hFF;
                        rem  <= 4'hF;
                        div0 <= 1'b1;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    prem  <= prem_nxt;
                    qwork <= qwork_nxt;
                    dvd   <= {dvd[6:0], 1'b0};
                    step  <= step + 3'd1;
                    if (step == 3'd7) begin
                        quot <= qwork_nxt;
                        rem  <= prem_nxt[3:0];
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign HEX0 = seg7(quot[3:0]);
    assign HEX1 = seg7(quot[7:4]);
    assign HEX2 = seg7(rem);
    assign HEX3 = 7'h7F;
    assign LEDR = {div0, busy, done, 3'b000, rem, quot};

endmodule

// File: tb/tb_seq_divider_hex.sv
// Directed bench for seq_divider_hex: table of divisions plus
// multi-cycle sequences (ignored press, async reset, debounce).
module tb_seq_divider_hex;

    logic        CLOCK_50 = 1'b0;
    logic [3:0]  KEY;
    logic [17:0] SW;
    logic [6:0]  HEX0;
    logic [6:0]  HEX1;
    logic [6:0]  HEX2;
    logic [6:0]  HEX3;
    logic [17:0] LEDR;

`ifdef DIV_DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 0;
`endif

    always #10 CLOCK_50 = ~CLOCK_50;

    seq_divider_hex #(.DEBOUNCE_CYCLES(8)) dut (
        .CLOCK_50(CLOCK_50),
        .KEY     (KEY),
        .SW      (SW),
        .HEX0    (HEX0),
        .HEX1    (HEX1),
        .HEX2    (HEX2),
        .HEX3    (HEX3),
        .LEDR    (LEDR)
    );

    typedef struct {
        logic [7:0] dvd;
        logic [3:0] dvs;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } vec_t;

    vec_t       vt[9];
    logic [6:0] seg_tab[16];
    int         n_chk;
    int         n_fail;
    logic [7:0] last_q;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ledr"}, LEDR, 0);
        chk({tag, "_hex0"}, HEX0, 7'h40);
        chk({tag, "_hex1"}, HEX1, 7'h40);
        chk({tag, "_hex2"}, HEX2, 7'h40);
        chk({tag, "_hex3"}, HEX3, 7'h7F);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        KEY[0] = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        repeat (6) @(posedge CLOCK_50);
        last_q = 8'h00;
    endtask

    task automatic chk_result(input logic [7:0] eq,
                              input logic [3:0] er,
                              input logic ez);
        chk("done", LEDR[15], 1);
        chk("busy_done", LEDR[16], 0);
        chk("div0", LEDR[17], ez);
        chk("quot", LEDR[7:0], eq);
        chk("rem", LEDR[11:8], er);
        chk("ledr_gap", LEDR[14:12], 0);
        chk("hex0", HEX0, seg_tab[eq[3:0]]);
        chk("hex1", HEX1, seg_tab[eq[7:4]]);
        chk("hex2", HEX2, seg_tab[er]);
        chk("hex3", HEX3, 7'h7F);
    endtask

    task automatic run_op(input logic [7:0] dvd,
                          input logic [3:0] dvs,
                          input logic [7:0] eq,
                          input logic [3:0] er,
                          input logic ez);
        int lat;
        lat = (ez ? 4 : 12) + DB;
        @(negedge CLOCK_50);
        SW = {dvs, 6'h00, dvd};
        KEY[1] = 1'b0;
        repeat (lat - 1) @(posedge CLOCK_50);
        #1;
        chk("pre_done", LEDR[15], 0);
        chk("busy_run", LEDR[16], 1);
        chk("hold_prev_q", LEDR[7:0], last_q);
        @(posedge CLOCK_50);
        #1;
        chk_result(eq, er, ez);
        last_q = eq;
        @(negedge CLOCK_50);
        KEY[1] = 1'b1;
        SW = 18'h3FFFF;
        repeat (DB + 5) @(posedge CLOCK_50);
        #1;
        chk("hold_q", LEDR[7:0], eq);
        chk("hold_done", LEDR[15], 1);
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30,
                    7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03,
                    7'h46, 7'h21, 7'h06, 7'h0E};
        vt[0] = '{8'd200, 4'd7,  8'h1C, 4'd4,  1'b0};
        vt[1] = '{8'd255, 4'd1,  8'hFF, 4'd0,  1'b0};
        vt[2] = '{8'd5,   4'd9,  8'h00, 4'd5,  1'b0};
        vt[3] = '{8'd77,  4'd0,  8'hFF, 4'hF,  1'b1};
        vt[4] = '{8'd100, 4'd10, 8'h0A, 4'd0,  1'b0};
        vt[5] = '{8'd15,  4'd15, 8'h01, 4'd0,  1'b0};
        vt[6] = '{8'd0,   4'd3,  8'h00, 4'd0,  1'b0};
        vt[7] = '{8'd254, 4'd15, 8'h10, 4'd14, 1'b0};
        vt[8] = '{8'd127, 4'd2,  8'h3F, 4'd1,  1'b0};

        n_chk  = 0;
        n_fail = 0;
        last_q = 8'h00;
        KEY = 4'b1110;
        SW  = 18'h0;
        #1;
        chk_reset_outputs("rst");
        #30;
        KEY[0] = 1'b1;
        repeat (6) @(posedge CLOCK_50);
        #1;
        chk_reset_outputs("idle");

        for (int i = 0; i < 9; i++) begin
            run_op(vt[i].dvd, vt[i].dvs, vt[i].q, vt[i].r, vt[i].z);
        end

        // Second press during RUN with new operands is ignored.
        @(negedge CLOCK_50);
        SW = {4'd7, 6'h00, 8'd200};
        KEY[1] = 1'b0;
        repeat (3 + DB) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        KEY[1] = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        SW = {4'd3, 6'h00, 8'd99};
        repeat (6) @(posedge CLOCK_50);
        #1;
        chk("ign_pre_done", LEDR[15], 0);
        @(posedge CLOCK_50);
        #1;
        chk_result(8'h1C, 4'd4, 1'b0);
        last_q = 8'h1C;
        @(negedge CLOCK_50);
        KEY[1] = 1'b1;
        repeat (DB + 5) @(posedge CLOCK_50);
        run_op(8'd99, 4'd3, 8'h21, 4'd0, 1'b0);

        // Asynchronous reset mid-RUN, key held low through release.
        @(negedge CLOCK_50);
        SW = {4'd7, 6'h00, 8'd200};
        KEY[1] = 1'b0;
        repeat (8 + DB) @(posedge CLOCK_50);
        #5;
        KEY[0] = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        repeat (2) @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        repeat (30 + 2 * DB) @(posedge CLOCK_50);
        #1;
        chk("no_start_after_rst", LEDR, 0);
        last_q = 8'h00;
        @(negedge CLOCK_50);
        KEY[1] = 1'b1;
        repeat (DB + 5) @(posedge CLOCK_50);
        run_op(8'd255, 4'd1, 8'hFF, 4'd0, 1'b0);

`ifdef DIV_DEBOUNCE_EN
        do_reset();
        @(negedge CLOCK_50);
        SW = {4'd7, 6'h00, 8'd200};
        KEY[1] = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        KEY[1] = 1'b1;
        repeat (30) @(posedge CLOCK_50);
        #1;
        chk("glitch_ignored", LEDR, 0);
        @(negedge CLOCK_50);
        KEY[1] = 1'b0;
        repeat (12) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        KEY[1] = 1'b1;
        repeat (7) @(posedge CLOCK_50);
        #1;
        chk("db_pre_done", LEDR[15], 0);
        chk("db_busy", LEDR[16], 1);
        @(posedge CLOCK_50);
        #1;
        chk_result(8'h1C, 4'd4, 1'b0);
        repeat (40) @(posedge CLOCK_50);
        #1;
        chk("single_start_busy", LEDR[16], 0);
        chk("single_start_done", LEDR[15], 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
